chip_idle_ctrl: RTL and testbench
=================================

# chip_idle_ctrl

Chip-level idle controller that consumes the combined `chip_is_idle` indication and acts on it. It qualifies sustained idleness against a programmable hold threshold, then runs a four-phase req/ack handshake with the top-level clock-gate cell. It releases the gate on a wake event or loss of idle, and pulses per-CPU wake lines on exit. It sits in the top cell between the idle generator and the clock/power gating logic.

## Interface
- `N_CPU`, default 5: number of CPU wake inputs and outputs.
- `CNT_W`, default 16: width of the idle hold counter, the threshold, and the entry counter.

- `clk`  in  1  chip clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `chip_is_idle`  in  1  combined idle indication.
- `idle_en`  in  1  enables idle entry; 0 forces exit or stay in RUN.
- `idle_thresh`  in  CNT_W  hold threshold; WAIT must last idle_thresh+1 cycles before the request.
- `wake_event`  in  N_CPU  per-CPU wake sources (level).
- `gate_ack`  in  1  clock-gate acknowledge, four-phase.
- `gate_req`  out  1  clock-gate request, registered.
- `cpu_wake`  out  N_CPU  one-cycle wake pulse per CPU, registered.
- `idle_state`  out  3  current FSM state: RUN=0, WAIT=1, REQ=2, GATED=3, EXIT=4.
- `idle_entries`  out  CNT_W  count of completed gate entries, saturating.

## Operation
- Definitions:
  - `wake_any` = |wake_event.
  - `stay` = chip_is_idle & idle_en & !wake_any.
- RUN (gate_req=0, cnt=0):
  - Goes to WAIT when stay & !gate_ack.
  - A stale ack holds RUN.
- WAIT (gate_req=0):
  - If !stay, go to RUN and clear cnt.
  - Else if cnt >= idle_thresh, go to REQ.
  - Else cnt++. cnt does not wrap, since it is bounded by idle_thresh.
- REQ (gate_req=1):
  - Waits for gate_ack=1.
  - On ack, if the abort flag is clear, go to GATED and increment idle_entries (saturates at 2^CNT_W-1). If the abort flag is set, go to EXIT with no increment.
  - Any !stay cycle while in REQ sets the abort flag.
  - gate_req never drops before ack.
- GATED (gate_req=1):
  - Goes to EXIT on !stay.
- EXIT (gate_req=0):
  - Waits for gate_ack=0, then goes to RUN.
  - On that transition, cpu_wake = wake_mask for exactly one cycle.
  - wake_mask and the abort flag clear on the transition.
- wake_mask:
  - ORs in wake_event every cycle in REQ, GATED and EXIT.
  - Is 0 in RUN and WAIT.
  - If exit is caused only by chip_is_idle or idle_en falling, cpu_wake pulses 0 (no pulse).
- Simultaneous events:
  - gate_ack rising with !stay in the same REQ cycle counts as abort: go to EXIT, no increment.
  - stay and gate_ack=1 together in RUN keep RUN.
- Reset: asynchronous; takes effect immediately, mid-handshake included.
  - State RUN; cnt, abort and wake_mask all 0.
  - Outputs: gate_req=0, cpu_wake=0, idle_state=0, idle_entries=0.
- idle_thresh and idle_en are sampled every cycle; changing idle_thresh during WAIT uses the new value on the next compare.

## Timing
- All outputs are registered; idle_state reflects the current state register.
- Entry latency, with stay=1 sampled at edge E0:
  - WAIT from E0.
  - REQ (gate_req=1) after edge E0+idle_thresh+1.
  - With idle_thresh=0, gate_req rises one cycle after WAIT is entered.
- REQ→GATED: the edge that samples gate_ack=1.
- GATED→EXIT: the edge that samples !stay; gate_req falls at that edge.
- EXIT→RUN: the edge that samples gate_ack=0; cpu_wake is high in the following cycle only.
- Minimum wake latency, from a wake_event sample to the cpu_wake pulse: 2 edges plus the ack-fall delay.

## Test plan
- Basic entry and exit:
  - Stimulus: rst release; idle_thresh=3; chip_is_idle=1, idle_en=1. The ack model responds in 2 cycles.
  - Required: gate_req rises exactly 4 cycles after WAIT entry; GATED; idle_entries=1.
  - Then wake_event=5'b00100 for 1 cycle. Required: gate_req falls; after ack falls, cpu_wake=5'b00100 for one cycle; state RUN.
- Glitched idle:
  - Stimulus: idle_thresh=10; chip_is_idle drops at cycle 6 of WAIT.
  - Required: return to RUN, gate_req never asserts, then a full 11-cycle requalification.
- Abort during REQ:
  - Stimulus: wake_event[1] pulses while waiting for ack.
  - Required: gate_req held until ack=1, then EXIT; idle_entries unchanged; cpu_wake=5'b00010.
- idle_thresh=0 and idle_en drop:
  - Required: gate_req rises 1 cycle after WAIT. Dropping idle_en in GATED gives EXIT, then cpu_wake=0 on the return to RUN.
- Reset mid-GATED, with gate_ack held at 1:
  - Required: all outputs 0 immediately. The FSM stays in RUN despite stay=1 until gate_ack=0.
- Saturation:
  - Stimulus: CNT_W=4; 17 entry/exit loops.
  - Required: idle_entries=15 and holds.

Source files
------------

// File: rtl/chip_idle_ctrl.sv
// chip_idle_ctrl: qualifies sustained chip idleness, runs a four-phase
// req/ack handshake with the top-level clock-gate cell and pulses per-CPU
// wake lines when the gate is released.
module chip_idle_ctrl #(
    parameter int unsigned N_CPU = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chip_is_idle,
    input  logic             idle_en,
    input  logic [CNT_W-1:0] idle_thresh,
    input  logic [N_CPU-1:0] wake_event,
    input  logic             gate_ack,
    output logic             gate_req,
    output logic [N_CPU-1:0] cpu_wake,
    output logic [2:0]       idle_state,
    output logic [CNT_W-1:0] idle_entries
);

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_WAIT  = 3'd1,
        ST_REQ   = 3'd2,
        ST_GATED = 3'd3,
        ST_EXIT  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] ENT_MAX = '1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               abort_q, abort_d;
    logic [N_CPU-1:0]   wake_mask_q, wake_mask_d;
    logic               gate_req_d;
    logic [N_CPU-1:0]   cpu_wake_d;
    logic [CNT_W-1:0]   entries_d;

    logic               wake_any;
    logic               stay;
    logic               abort_now;

    // Idle qualification terms; a !stay cycle in REQ aborts the pending entry.
    assign wake_any  = |wake_event;
    assign stay      = chip_is_idle & idle_en & ~wake_any;
    assign abort_now = abort_q | ~stay;

    // Next-state, counters, wake mask and registered-output next values.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        abort_d     = abort_q;
        wake_mask_d = wake_mask_q;
        cpu_wake_d  = '0;
        entries_d   = idle_entries;

        case (state_q)
            ST_RUN: begin
                cnt_d       = '0;
                abort_d     = 1'b0;
                wake_mask_d = '0;
                // A stale ack from a previous handshake blocks entry.
                if (stay && !gate_ack) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                wake_mask_d = '0;
                if (!stay) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (cnt_q >= idle_thresh) begin
                    state_d = ST_REQ;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_REQ: begin
                wake_mask_d = wake_mask_q | wake_event;
                abort_d     = abort_now;
                // Request is held until ack regardless of abort.
                if (gate_ack) begin
                    if (abort_now) begin
                        state_d = ST_EXIT;
                    end else begin
                        state_d = ST_GATED;
                        if (idle_entries != ENT_MAX) begin
                            entries_d = idle_entries + CNT_W'(1);
                        end
                    end
                end
            end

            ST_GATED: begin
                wake_mask_d = wake_mask_q | wake_event;
                if (!stay) begin
                    state_d = ST_EXIT;
                end
            end

            ST_EXIT: begin
                wake_mask_d = wake_mask_q | wake_event;
                if (!gate_ack) begin
                    state_d     = ST_RUN;
                    cpu_wake_d  = wake_mask_q | wake_event;
                    wake_mask_d = '0;
                    abort_d     = 1'b0;
                end
            end

            default: begin
                state_d     = ST_RUN;
                cnt_d       = '0;
                abort_d     = 1'b0;
                wake_mask_d = '0;
            end
        endcase

        gate_req_d = (state_d == ST_REQ) || (state_d == ST_GATED);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            cnt_q        <= '0;
            abort_q      <= 1'b0;
            wake_mask_q  <= '0;
            gate_req     <= 1'b0;
            cpu_wake     <= '0;
            idle_entries <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            abort_q      <= abort_d;
            wake_mask_q  <= wake_mask_d;
            gate_req     <= gate_req_d;
            cpu_wake     <= cpu_wake_d;
            idle_entries <= entries_d;
        end
    end

    // Current state is exported directly from the state register.
    assign idle_state = 3'(state_q);

endmodule

// File: tb/tb_chip_idle_ctrl.sv
// Testbench for chip_idle_ctrl: table-driven vectors plus hand sequences,
// with expected outputs queued at drive time and popped after each edge.
// A second instance with a 4-bit counter width shares the stimulus and
// is used to observe entry-count saturation.
module tb_chip_idle_ctrl;

    logic        clk;
    logic        rst;
    logic        chip_is_idle;
    logic        idle_en;
    logic [15:0] thresh;
    logic [4:0]  wake_event;
    logic        gate_ack;

    logic        gate_req;
    logic [4:0]  cpu_wake;
    logic [2:0]  idle_state;
    logic [15:0] idle_entries;

    logic        sat_req;
    logic [4:0]  sat_wake;
    logic [2:0]  sat_state;
    logic [3:0]  sat_ent;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        idle;
        logic        en;
        logic [4:0]  wake;
        logic        ack;
        logic [15:0] thr;
        logic [2:0]  st;
        logic        req;
        logic [4:0]  cw;
        logic [15:0] ent;
    } vec_t;

    typedef struct {
        logic [2:0]  st;
        logic        req;
        logic [4:0]  cw;
        logic [15:0] ent;
        logic [3:0]  sat_ent;
    } exp_t;

    exp_t exp_q[$];
    vec_t tbl[$];

    chip_idle_ctrl #(.N_CPU(5), .CNT_W(16)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .chip_is_idle (chip_is_idle),
        .idle_en      (idle_en),
        .idle_thresh  (thresh),
        .wake_event   (wake_event),
        .gate_ack     (gate_ack),
        .gate_req     (gate_req),
        .cpu_wake     (cpu_wake),
        .idle_state   (idle_state),
        .idle_entries (idle_entries)
    );

    chip_idle_ctrl #(.N_CPU(5), .CNT_W(4)) u_sat (
        .clk          (clk),
        .rst          (rst),
        .chip_is_idle (chip_is_idle),
        .idle_en      (idle_en),
        .idle_thresh  (thresh[3:0]),
        .wake_event   (wake_event),
        .gate_ack     (gate_ack),
        .gate_req     (sat_req),
        .cpu_wake     (sat_wake),
        .idle_state   (sat_state),
        .idle_entries (sat_ent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic idle, input logic en, input logic [4:0] wake,
                                input logic ack, input logic [15:0] thr, input logic [2:0] st,
                                input logic req, input logic [4:0] cw, input logic [15:0] ent);
        vec_t v;
        v.idle = idle; v.en = en; v.wake = wake; v.ack = ack; v.thr = thr;
        v.st = st; v.req = req; v.cw = cw; v.ent = ent;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Queue the outputs expected after the next update.
    task automatic push_exp(input logic [2:0] st, input logic req, input logic [4:0] cw,
                            input logic [15:0] ent);
        exp_t e;
        e.st = st; e.req = req; e.cw = cw; e.ent = ent;
        e.sat_ent = (ent > 16'd15) ? 4'd15 : ent[3:0];
        exp_q.push_back(e);
    endtask

    // Pop the oldest expectation and compare both instances against it.
    task automatic compare_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard: queue empty, want 1 entry");
        end else begin
            e = exp_q.pop_front();
            chk("idle_state",   32'(idle_state),   32'(e.st));
            chk("gate_req",     32'(gate_req),     32'(e.req));
            chk("cpu_wake",     32'(cpu_wake),     32'(e.cw));
            chk("idle_entries", 32'(idle_entries), 32'(e.ent));
            chk("sat_state",    32'(sat_state),    32'(e.st));
            chk("sat_req",      32'(sat_req),      32'(e.req));
            chk("sat_wake",     32'(sat_wake),     32'(e.cw));
            chk("sat_entries",  32'(sat_ent),      32'(e.sat_ent));
        end
    endtask

    task automatic step(input logic idle, input logic en, input logic [4:0] wake,
                        input logic ack, input logic [2:0] st, input logic req,
                        input logic [4:0] cw, input logic [15:0] ent);
        chip_is_idle = idle;
        idle_en      = en;
        wake_event   = wake;
        gate_ack     = ack;
        push_exp(st, req, cw, ent);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    initial begin
        // Basic entry/exit, threshold 3, ack two cycles after request.
        tbl.push_back(mk(1, 1, 5'b00000, 0, 16'd3, 3'd1, 0, 5'b00000, 16'd0));
        tbl.push_back(mk(1, 1, 5'b00000, 0, 16'd3, 3'd1, 0, 5'b00000, 16'd0));
        tbl.push_back(mk(1, 1, 5'b00000, 0, 16'd3, 3'd1, 0, 5'b00000, 16'd0));
        tbl.push_back(mk(1, 1, 5'b00000, 0, 16'd3, 3'd1, 0, 5'b00000, 16'd0));
        tbl.push_back(mk(1, 1, 5'b00000, 0, 16'd3, 3'd2, 1, 5'b00000, 16'd0));
        tbl.push_back(mk(1, 1, 5'b00000, 0, 16'd3, 3'd2, 1, 5'b00000, 16'd0));
        tbl.push_back(mk(1, 1, 5'b00000, 1, 16'd3, 3'd3, 1, 5'b00000, 16'd1));
        tbl.push_back(mk(1, 1, 5'b00000, 1, 16'd3, 3'd3, 1, 5'b00000, 16'd1));
        tbl.push_back(mk(1, 1, 5'b00100, 1, 16'd3, 3'd4, 0, 5'b00000, 16'd1));
        tbl.push_back(mk(1, 1, 5'b00000, 1, 16'd3, 3'd4, 0, 5'b00000, 16'd1));
        tbl.push_back(mk(1, 1, 5'b00000, 0, 16'd3, 3'd0, 0, 5'b00100, 16'd1));
        tbl.push_back(mk(0, 1, 5'b00000, 0, 16'd3, 3'd0, 0, 5'b00000, 16'd1));
        // Abort: wake during REQ, request held until ack, no entry count.
        tbl.push_back(mk(1, 1, 5'b00000, 0, 16'd2, 3'd1, 0, 5'b00000, 16'd1));
        tbl.push_back(mk(1, 1, 5'b00000, 0, 16'd2, 3'd1, 0, 5'b00000, 16'd1));
        tbl.push_back(mk(1, 1, 5'b00000, 0, 16'd2, 3'd1, 0, 5'b00000, 16'd1));
        tbl.push_back(mk(1, 1, 5'b00000, 0, 16'd2, 3'd2, 1, 5'b00000, 16'd1));
        tbl.push_back(mk(1, 1, 5'b00010, 0, 16'd2, 3'd2, 1, 5'b00000, 16'd1));
        tbl.push_back(mk(1, 1, 5'b00000, 0, 16'd2, 3'd2, 1, 5'b00000, 16'd1));
        tbl.push_back(mk(1, 1, 5'b00000, 1, 16'd2, 3'd4, 0, 5'b00000, 16'd1));
        tbl.push_back(mk(1, 1, 5'b00000, 1, 16'd2, 3'd4, 0, 5'b00000, 16'd1));
        tbl.push_back(mk(1, 1, 5'b00000, 0, 16'd2, 3'd0, 0, 5'b00010, 16'd1));
        tbl.push_back(mk(0, 1, 5'b00000, 0, 16'd2, 3'd0, 0, 5'b00000, 16'd1));
        // Ack rising together with idle loss in REQ; stale ack holds RUN.
        tbl.push_back(mk(1, 1, 5'b00000, 0, 16'd0, 3'd1, 0, 5'b00000, 16'd1));
        tbl.push_back(mk(1, 1, 5'b00000, 0, 16'd0, 3'd2, 1, 5'b00000, 16'd1));
        tbl.push_back(mk(0, 1, 5'b00000, 1, 16'd0, 3'd4, 0, 5'b00000, 16'd1));
        tbl.push_back(mk(0, 1, 5'b00000, 0, 16'd0, 3'd0, 0, 5'b00000, 16'd1));
        tbl.push_back(mk(1, 1, 5'b00000, 1, 16'd0, 3'd0, 0, 5'b00000, 16'd1));
        tbl.push_back(mk(0, 1, 5'b00000, 0, 16'd0, 3'd0, 0, 5'b00000, 16'd1));
        // Threshold 0, then idle_en drop in GATED gives an empty wake pulse.
        tbl.push_back(mk(1, 1, 5'b00000, 0, 16'd0, 3'd1, 0, 5'b00000, 16'd1));
        tbl.push_back(mk(1, 1, 5'b00000, 0, 16'd0, 3'd2, 1, 5'b00000, 16'd1));
        tbl.push_back(mk(1, 1, 5'b00000, 1, 16'd0, 3'd3, 1, 5'b00000, 16'd2));
        tbl.push_back(mk(1, 0, 5'b00000, 1, 16'd0, 3'd4, 0, 5'b00000, 16'd2));
        tbl.push_back(mk(1, 0, 5'b00000, 0, 16'd0, 3'd0, 0, 5'b00000, 16'd2));
        tbl.push_back(mk(1, 0, 5'b00000, 0, 16'd0, 3'd0, 0, 5'b00000, 16'd2));

        // Reset state.
        rst = 1'b1; chip_is_idle = 1'b0; idle_en = 1'b0; thresh = 16'd0;
        wake_event = '0; gate_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        push_exp(3'd0, 1'b0, 5'b00000, 16'd0);
        compare_out();
        rst = 1'b0;

        foreach (tbl[i]) begin
            thresh = tbl[i].thr;
            step(tbl[i].idle, tbl[i].en, tbl[i].wake, tbl[i].ack,
                 tbl[i].st, tbl[i].req, tbl[i].cw, tbl[i].ent);
        end

        // Glitched idle: drop on the 6th WAIT cycle, then full requalification.
        thresh = 16'd10;
        step(1, 1, 5'b0, 0, 3'd1, 0, 5'b0, 16'd2);
        for (int i = 0; i < 5; i++) step(1, 1, 5'b0, 0, 3'd1, 0, 5'b0, 16'd2);
        step(0, 1, 5'b0, 0, 3'd0, 0, 5'b0, 16'd2);
        step(1, 1, 5'b0, 0, 3'd1, 0, 5'b0, 16'd2);
        for (int i = 0; i < 10; i++) step(1, 1, 5'b0, 0, 3'd1, 0, 5'b0, 16'd2);
        step(1, 1, 5'b0, 0, 3'd2, 1, 5'b0, 16'd2);
        step(1, 1, 5'b0, 1, 3'd3, 1, 5'b0, 16'd3);

        // Asynchronous reset while GATED with ack still high.
        rst = 1'b1;
        #1;
        push_exp(3'd0, 1'b0, 5'b00000, 16'd0);
        compare_out();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1, 1, 5'b0, 1, 3'd0, 0, 5'b0, 16'd0);
        step(1, 1, 5'b0, 0, 3'd1, 0, 5'b0, 16'd0);
        step(0, 1, 5'b0, 0, 3'd0, 0, 5'b0, 16'd0);

        // Entry/exit loops; the 4-bit instance saturates at 15 and holds.
        thresh = 16'd0;
        for (int k = 0; k < 17; k++) begin
            step(1, 1, 5'b0, 0, 3'd1, 0, 5'b0, 16'(k));
            step(1, 1, 5'b0, 0, 3'd2, 1, 5'b0, 16'(k));
            step(1, 1, 5'b0, 1, 3'd3, 1, 5'b0, 16'(k + 1));
            step(0, 1, 5'b0, 1, 3'd4, 0, 5'b0, 16'(k + 1));
            step(0, 1, 5'b0, 0, 3'd0, 0, 5'b0, 16'(k + 1));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
